// File: rtl/da_lms_frame_sequencer.sv
// Frame sequencer for the DA LMS filter: capture 16 samples, DA bit-serial compute,
// error latch, optional weight-update sweep, frame-done; Moore outputs, combinational load strobe.
module da_lms_frame_sequencer #(
    parameter int NTAPS = 16,
    parameter int IDXW  = 4,
    parameter int DW    = 8,
    parameter int BITW  = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            run_i,
    input  logic            adapt_en_i,
    input  logic            xin_valid_i,
    output logic            xin_ready_o,
    output logic            load_en_o,
    output logic [IDXW-1:0] load_idx_o,
    output logic            acc_clr_o,
    output logic            acc_en_o,
    output logic [BITW-1:0] bit_idx_o,
    output logic            acc_sub_o,
    output logic            err_latch_o,
    output logic            upd_en_o,
    output logic [IDXW-1:0] upd_idx_o,
    output logic            frame_done_o,
    output logic            busy_o
);

    localparam int CW = (IDXW > BITW) ? IDXW : BITW;
    localparam logic [CW-1:0] TAP_LAST = CW'(NTAPS - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_ERR,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            xin_ready_q, xin_ready_d;
    logic            acc_clr_q, acc_clr_d;
    logic            acc_en_q, acc_en_d;
    logic [BITW-1:0] bit_idx_q, bit_idx_d;
    logic            acc_sub_q, acc_sub_d;
    logic            err_latch_q, err_latch_d;
    logic            upd_en_q, upd_en_d;
    logic [IDXW-1:0] upd_idx_q, upd_idx_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;

    // One shared counter serves as slot, bit and tap index; it is zero on entry to every phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (xin_valid_i) begin
                    if (cnt_q == TAP_LAST) begin
                        cnt_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ERR: begin
                cnt_d   = '0;
                state_d = adapt_en_i ? S_UPDATE : S_DONE;
            end
            S_UPDATE: begin
                if (cnt_q == TAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = run_i ? S_LOAD : S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        xin_ready_d  = (state_d == S_LOAD);
        acc_en_d     = (state_d == S_COMPUTE);
        acc_clr_d    = (state_d == S_COMPUTE) && (cnt_d == '0);
        acc_sub_d    = (state_d == S_COMPUTE) && (cnt_d == BIT_LAST);
        bit_idx_d    = (state_d == S_COMPUTE) ? cnt_d[BITW-1:0] : '0;
        err_latch_d  = (state_d == S_ERR);
        upd_en_d     = (state_d == S_UPDATE);
        upd_idx_d    = (state_d == S_UPDATE) ? cnt_d[IDXW-1:0] : '0;
        frame_done_d = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            xin_ready_q  <= 1'b0;
            acc_clr_q    <= 1'b0;
            acc_en_q     <= 1'b0;
            bit_idx_q    <= '0;
            acc_sub_q    <= 1'b0;
            err_latch_q  <= 1'b0;
            upd_en_q     <= 1'b0;
            upd_idx_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            xin_ready_q  <= xin_ready_d;
            acc_clr_q    <= acc_clr_d;
            acc_en_q     <= acc_en_d;
            bit_idx_q    <= bit_idx_d;
            acc_sub_q    <= acc_sub_d;
            err_latch_q  <= err_latch_d;
            upd_en_q     <= upd_en_d;
            upd_idx_q    <= upd_idx_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // The capture strobe must hit the bank in the same cycle the sample is offered.
    assign load_en_o    = xin_ready_q & xin_valid_i;
    assign load_idx_o   = xin_ready_q ? cnt_q[IDXW-1:0] : '0;

    assign xin_ready_o  = xin_ready_q;
    assign acc_clr_o    = acc_clr_q;
    assign acc_en_o     = acc_en_q;
    assign bit_idx_o    = bit_idx_q;
    assign acc_sub_o    = acc_sub_q;
    assign err_latch_o  = err_latch_q;
    assign upd_en_o     = upd_en_q;
    assign upd_idx_o    = upd_idx_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;

endmodule
